// File: rtl/shift_sequencer_if.sv
// Start/busy/done handshake between the multi-cycle control unit and shift_sequencer.
// master = control unit, slave = sequencer.
interface shift_sequencer_if #(
   parameter int unsigned AMT_W = 3
);
   logic             start;
   logic [7:0]       data_in;
   logic [2:0]       type_in;
   logic [AMT_W-1:0] amt_in;
   logic             busy;
   logic             done;
   logic             err;
   logic [7:0]       result;

   modport master (
      output start, data_in, type_in, amt_in,
      input  busy, done, err, result
   );

   modport slave (
      input  start, data_in, type_in, amt_in,
      output busy, done, err, result
   );
endinterface

// File: rtl/shift_sequencer.sv
// Multi-cycle shift/rotate controller iterating a single-bit combinational shifter once per clock.
// Optional carry_out/zero flag outputs are enabled with macro SHSEQ_FLAGS_EN.
module shift_sequencer #(
   parameter int unsigned AMT_W = 3
) (
   input  logic                clk,
   input  logic                rst,
   shift_sequencer_if.slave    ctl,
   output logic [7:0]          sh_data,
   output logic [2:0]          sh_type,
`ifdef SHSEQ_FLAGS_EN
   output logic                carry_out,
   output logic                zero,
`endif
   input  logic [7:0]          sh_result
);

   localparam int unsigned DATA_W = 8;
   localparam int unsigned TYPE_W = 3;
   localparam logic [TYPE_W-1:0] TYPE_MAX = TYPE_W'(4);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t              state,     state_nx;
   logic [DATA_W-1:0]   work,      work_nx;
   logic [TYPE_W-1:0]   typ,       typ_nx;
   logic [AMT_W-1:0]    cnt,       cnt_nx;
   logic [DATA_W-1:0]   result_q,  result_nx;
   logic                err_flag,  err_flag_nx;
   logic                busy_q,    busy_nx;
   logic                done_q,    done_nx;
   logic                err_q,     err_nx;
`ifdef SHSEQ_FLAGS_EN
   logic                carry_q,   carry_nx;
   logic                zero_q,    zero_nx;
   logic                bit_out;
`endif

   // State and datapath registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         work     <= '0;
         typ      <= '0;
         cnt      <= '0;
         result_q <= '0;
         err_flag <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
`ifdef SHSEQ_FLAGS_EN
         carry_q  <= 1'b0;
         zero_q   <= 1'b0;
`endif
      end else begin
         state    <= state_nx;
         work     <= work_nx;
         typ      <= typ_nx;
         cnt      <= cnt_nx;
         result_q <= result_nx;
         err_flag <= err_flag_nx;
         busy_q   <= busy_nx;
         done_q   <= done_nx;
         err_q    <= err_nx;
`ifdef SHSEQ_FLAGS_EN
         carry_q  <= carry_nx;
         zero_q   <= zero_nx;
`endif
      end
   end

   // Next-state and datapath update; handshake outputs are registered from the next state
   always_comb begin
      state_nx    = state;
      work_nx     = work;
      typ_nx      = typ;
      cnt_nx      = cnt;
      result_nx   = result_q;
      err_flag_nx = err_flag;
`ifdef SHSEQ_FLAGS_EN
      carry_nx    = carry_q;
      zero_nx     = zero_q;
      // Bit that leaves the register on this step: MSB for left ops, LSB for right ops
      bit_out     = (typ == TYPE_W'(0) || typ == TYPE_W'(2)) ? work[DATA_W-1] : work[0];
`endif

      unique case (state)
         IDLE: begin
            if (ctl.start) begin
               work_nx = ctl.data_in;
               typ_nx  = ctl.type_in;
               cnt_nx  = ctl.amt_in;
               if (ctl.type_in > TYPE_MAX) begin
                  state_nx    = DONE;
                  result_nx   = ctl.data_in;
                  err_flag_nx = 1'b1;
               end else if (ctl.amt_in == '0) begin
                  state_nx    = DONE;
                  result_nx   = ctl.data_in;
                  err_flag_nx = 1'b0;
               end else begin
                  state_nx    = RUN;
                  err_flag_nx = 1'b0;
               end
`ifdef SHSEQ_FLAGS_EN
               if (state_nx == DONE) begin
                  carry_nx = 1'b0;
                  zero_nx  = (ctl.data_in == '0);
               end
`endif
            end
         end
         RUN: begin
            work_nx = sh_result;
            cnt_nx  = cnt - AMT_W'(1);
            if (cnt == AMT_W'(1)) begin
               state_nx  = DONE;
               result_nx = sh_result;
`ifdef SHSEQ_FLAGS_EN
               carry_nx  = bit_out;
               zero_nx   = (sh_result == '0);
`endif
            end
         end
         DONE: begin
            state_nx = IDLE;
         end
         default: begin
            state_nx = IDLE;
         end
      endcase

      busy_nx = (state_nx != IDLE);
      done_nx = (state_nx == DONE);
      err_nx  = (state_nx == DONE) && err_flag_nx;
   end

   assign sh_data    = work;
   assign sh_type    = typ;
   assign ctl.busy   = busy_q;
   assign ctl.done   = done_q;
   assign ctl.err    = err_q;
   assign ctl.result = result_q;
`ifdef SHSEQ_FLAGS_EN
   assign carry_out  = carry_q;
   assign zero       = zero_q;
`endif

endmodule

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
- Multi-cycle controller that sits directly upstream of the single-bit combinational shifter in the datapath and consumes its output.
- Performs shift/rotate by 0..7 positions by iterating the shifter once per clock. It drives the shifter's data and type inputs from a working register, then captures the shifter's output back into that register.
- Provides a start/busy/done handshake to the multi-cycle control unit and holds the final result until the next accepted start.

Parameters:
- AMT_W, 3, width of the shift-amount input; maximum amount is 2^AMT_W-1. Data width is fixed at 8 to match the shifter.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request pulse; sampled only in IDLE.
- data_in  input  8  operand.
- type_in  input  3  operation code. 0 = rotate left, 1 = rotate right, 2 = shift left, 3 = arithmetic shift right, 4 = logical shift right.
- amt_in  input  AMT_W  number of single-bit steps.
- sh_data  output  8  to shifter data input; equals the working register.
- sh_type  output  3  to shifter type input; equals the latched type.
- sh_result  input  8  from shifter output.
- busy  output  1  high in RUN and DONE.
- done  output  1  one-cycle pulse when result is valid.
- err  output  1  high with done when the type was illegal (5..7).
- result  output  8  final value; held until the next accepted start.

Behaviour:
- Reset (async, rst=1): state=IDLE; work, type register, counter, result, done, err, busy all 0; sh_data=0, sh_type=0. Applies immediately, including mid-operation; the in-flight operation is discarded with no done pulse.
- IDLE, start=1 at a clock edge:
  - work<=data_in, typ<=type_in, cnt<=amt_in.
  - If type_in>4: go to DONE, result<=data_in, err<=1.
  - Else if amt_in==0: go to DONE, result<=data_in, err<=0.
  - Else: go to RUN, err<=0.
- IDLE, start=0: hold all registers.
- RUN, each edge:
  - work<=sh_result; cnt<=cnt-1.
  - If cnt==1: result<=sh_result, go to DONE.
- DONE: done=1 and busy=1 for exactly one cycle, then IDLE unconditionally. done and err are registered, decoded from state/flag.
- Latency: for start sampled at edge E0, done is high in the cycle after edge E0+N for amount N≥1, and in the cycle after E0 for N=0 or an illegal type.
- start during RUN or DONE is ignored, not queued. A start in the same cycle the block returns to IDLE is not seen; it is sampled on the following edge.
- sh_type is held at typ during IDLE/DONE. This keeps the shifter's combinational output stable and defined (typ≤4 whenever RUN is entered).
- Counter never wraps: RUN is entered only with cnt≥1 and exits at cnt==1.
- result changes only on the edge entering DONE. It is stable in IDLE.

Optional Feature:
- Macro SHSEQ_FLAGS_EN.
- Defined: adds outputs carry_out (1) and zero (1), both reset to 0.
  - carry_out = the last bit shifted out: work[7] for types 0/2, work[0] for types 1/3/4. It is captured on each RUN edge and is 0 for amount 0 or an illegal type.
  - zero = (result==0). Both update on the edge entering DONE and hold until the next DONE.
- Undefined: ports absent; no flag logic.

Test Plan:
- Rotate left, data 0x81, amt 1 -> done the cycle after edge 2; result 0x03; err 0.
- Shift left, data 0x01, amt 7 -> 7 RUN cycles, sh_data sequence 0x01,0x02,…,0x40; result 0x80; with flags, carry_out 0, zero 0.
- Arithmetic shift right, data 0x80, amt 3 -> result 0xF0. Logical shift right, same data and amount -> result 0x10. Logical shift right, data 0x01, amt 1 -> result 0x00, with flags zero=1 and carry_out=1.
- amt 0, data 0x5A, type 1 -> done one cycle after start; result 0x5A; no RUN state.
- type 6, data 0x33, amt 4 -> done next cycle with err=1, result 0x33. Also: second start asserted during RUN is ignored, and the first result is unaffected.
- rst pulsed during RUN of an amt 5 operation -> all outputs 0 immediately. No done pulse follows. A new start after release completes normally.
